// File: rtl/tx_egress_arbiter_if.sv
// tx_egress_arbiter_if: per-queue request bundle and TX byte path for tx_egress_arbiter (tx_abort exists only with TX_ARB_WDOG_EN)
interface tx_egress_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int GW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          tx_valid;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_last;
   logic                          tx_ready;
   logic [GW-1:0]                 grant_id;
   logic                          busy;
`ifdef TX_ARB_WDOG_EN
   logic                          tx_abort;
`endif
   modport master (
      output req_valid, req_data, req_last, tx_ready,
`ifdef TX_ARB_WDOG_EN
      input  tx_abort,
`endif
      input  req_ready, tx_valid, tx_data, tx_last, grant_id, busy
   );
   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
`ifdef TX_ARB_WDOG_EN
      output tx_abort,
`endif
      output req_ready, tx_valid, tx_data, tx_last, grant_id, busy
   );
endinterface

// File: rtl/tx_egress_arbiter.sv
// tx_egress_arbiter: frame-granular round-robin arbiter onto one TX byte path with a fixed post-frame gap; macro TX_ARB_WDOG_EN adds an underrun watchdog (FLUSH state, tx_abort)
module tx_egress_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IFG_BYTES  = 12
`ifdef TX_ARB_WDOG_EN
   ,
   parameter int WDOG_CYCLES = 64
`endif
) (
   input logic                clk,
   input logic                rst_n_in,
   tx_egress_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
   typedef enum logic [1:0] {
      IDLE, XFER, IFG
`ifdef TX_ARB_WDOG_EN
      , FLUSH
`endif
   } state_t;
   state_t                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d, rr_q, rr_d, win, idx;
   logic [CW-1:0]         ifg_q, ifg_d;
   logic                  found, g_valid, g_last, done;
   logic [DATA_WIDTH-1:0] g_data;
   logic [NUM_REQ-1:0]    g_hot;
`ifdef TX_ARB_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          abort_q, abort_d;
   assign bus.tx_abort = abort_q;
`endif

   assign bus.grant_id = grant_q;
   assign bus.busy     = state_q != IDLE;

   // first requester at or above rr_ptr (wrapping), and the granted queue's beat
   always_comb begin
      win     = rr_q;
      idx     = rr_q;
      found   = 1'b0;
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      g_hot   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = GW'((int'(rr_q) + k) % NUM_REQ);
         if (!found && bus.req_valid[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == GW'(i)) begin
            g_valid  = bus.req_valid[i];
            g_last   = bus.req_last[i];
            g_data   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            g_hot[i] = 1'b1;
         end
      end
   end

   // next state and pass-through outputs; a completed frame always advances rr_ptr and opens the gap
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_d          = rr_q;
      ifg_d         = ifg_q;
      done          = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.tx_last   = 1'b0;
      bus.req_ready = '0;
`ifdef TX_ARB_WDOG_EN
      wd_d          = '0;
      abort_d       = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = win;
               state_d = XFER;
            end
         end
         XFER: begin
            bus.tx_valid  = g_valid;
            bus.tx_data   = g_data;
            bus.tx_last   = g_last;
            bus.req_ready = bus.tx_ready ? g_hot : '0;
            done          = g_valid & bus.tx_ready & g_last;
`ifdef TX_ARB_WDOG_EN
            wd_d = g_valid ? '0 : wd_q + 1'b1;
            if (!g_valid && wd_q == WW'(WDOG_CYCLES - 1)) begin
               state_d = FLUSH;
               abort_d = 1'b1;
            end
`endif
         end
         IFG: begin
            if (ifg_q == '0) state_d = IDLE;
            else ifg_d = ifg_q - 1'b1;
         end
`ifdef TX_ARB_WDOG_EN
         FLUSH: begin
            bus.req_ready = g_hot;
            done          = g_valid & g_last;
         end
`endif
         default: state_d = IDLE;
      endcase
      if (done) begin
         rr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
         state_d = (IFG_BYTES > 0) ? IFG : IDLE;
         ifg_d   = CW'((IFG_BYTES > 0) ? IFG_BYTES - 1 : 0);
      end
   end

   // state registers; reset abandons any frame in flight
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         ifg_q   <= '0;
`ifdef TX_ARB_WDOG_EN
         wd_q    <= '0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         ifg_q   <= ifg_d;
`ifdef TX_ARB_WDOG_EN
         wd_q    <= wd_d;
         abort_q <= abort_d;
`endif
      end
   end
endmodule

// File: tb/tb_tx_egress_arbiter.sv
// tb_tx_egress_arbiter: vector table, directed frame sequences and randomized traffic against a frame-level round-robin model
module tb_tx_egress_arbiter;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int IFG = 12;

   logic clk = 1'b0;
   logic rst_n_in = 1'b0;
   always #5 clk = ~clk;

   tx_egress_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
   tx_egress_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .IFG_BYTES(IFG)) dut (
      .clk(clk), .rst_n_in(rst_n_in), .bus(bus));

`ifdef TX_ARB_WDOG_EN
   logic wrst_n = 1'b0;
   tx_egress_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) wb ();
   tx_egress_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .IFG_BYTES(0), .WDOG_CYCLES(8)) dut_w (
      .clk(clk), .rst_n_in(wrst_n), .bus(wb));
`endif

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {int g; logic [8:0] b;} beat_t;
   typedef struct {logic [3:0] mask; int exp_g;} vec_t;

   logic [8:0] src[N][$];
   int hold[N], stall_after[N], stall_len[N], fbeats[N];
   bit mid[N], sx[N];
   beat_t exp_q[$];
   int glog[$];
   int m_ptr = 0, cyc = 0, last_cyc = 0, busy_cnt = 0;
   int ready_mode = 0, underrun_pct = 0;
   bit had_last = 0, first_pending = 1;

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         src[i].delete();
         hold[i] = 0; stall_after[i] = -1; stall_len[i] = 0; fbeats[i] = 0;
         mid[i] = 0; sx[i] = 0;
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n_in = 1'b0;
      clear_src();
      bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n_in = 1'b1;
      m_ptr = 0;
   endtask

   task automatic load(input int q, input int len, input int base);
      for (int j = 0; j < len; j++) src[q].push_back({j == len - 1, 8'(base + j)});
   endtask

   // frame-level model: whole frames leave in round-robin order from the pointer after the last served queue
   task automatic plan();
      logic [8:0] c[N][$];
      logic [8:0] b;
      int sel;
      for (int i = 0; i < N; i++) c[i] = src[i];
      while (1) begin
         sel = -1;
         for (int k = 0; k < N; k++)
            if (sel < 0 && c[(m_ptr + k) % N].size() > 0) sel = (m_ptr + k) % N;
         if (sel < 0) break;
         do begin
            b = c[sel].pop_front();
            exp_q.push_back('{sel, b});
         end while (!b[8]);
         m_ptr = (sel + 1) % N;
      end
   endtask

   // one clock: retire last cycle's accepted beats, drive sources, then sample and check
   task automatic step();
      logic [8:0] b;
      logic [N*DW-1:0] dv;
      int g, nsx;
      beat_t e;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (sx[i] && src[i].size() > 0) begin
            b = src[i].pop_front();
            mid[i] = !b[8];
            fbeats[i] = b[8] ? 0 : fbeats[i] + 1;
            if (!b[8] && fbeats[i] == stall_after[i]) begin
               hold[i] = stall_len[i];
               stall_after[i] = -1;
            end
         end
      end
      dv = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i] = src[i].size() > 0 && hold[i] == 0 &&
                            !(mid[i] && $urandom_range(0, 99) < underrun_pct);
         bus.req_last[i]  = src[i].size() > 0 ? src[i][0][8] : 1'b0;
         dv[i*DW +: DW]   = src[i].size() > 0 ? src[i][0][7:0] : 8'h00;
         if (hold[i] > 0) hold[i]--;
      end
      bus.req_data = dv;
      bus.tx_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      #1;
      g = int'(bus.grant_id);
      nsx = 0;
      for (int i = 0; i < N; i++) begin
         sx[i] = bus.req_valid[i] & bus.req_ready[i];
         nsx += int'(sx[i]);
      end
      chk("one_source_per_tx_beat", nsx, bus.tx_valid & bus.tx_ready);
      chk("ready_only_granted", bus.req_ready & ~(N'(1) << g), 0);
      if (bus.tx_valid)
         chk("pass_through", {bus.req_valid[g], bus.req_last[g], bus.req_data[g*DW +: DW], bus.req_ready},
             {1'b1, bus.tx_last, bus.tx_data, bus.tx_ready ? (N'(1) << g) : N'(0)});
      if (bus.tx_valid && bus.tx_ready) begin
         if (exp_q.size() == 0) chk("unexpected_beat", {bus.grant_id, bus.tx_data}, 0);
         else begin
            e = exp_q.pop_front();
            chk("beat", {g, bus.tx_last, bus.tx_data}, {e.g, e.b});
         end
         if (first_pending) begin
            glog.push_back(g);
            if (had_last && ready_mode == 0) chk("frame_gap", cyc - last_cyc, IFG + 2);
         end
         first_pending = bus.tx_last;
         if (bus.tx_last) begin
            last_cyc = cyc;
            had_last = 1;
         end
      end
      if (had_last && cyc == last_cyc + IFG) chk("ifg_busy", bus.busy, 1);
      if (had_last && cyc == last_cyc + IFG + 1) chk("ifg_end", bus.busy, 0);
      busy_cnt += int'(bus.busy);
      cyc++;
   endtask

   task automatic run_all(input int budget);
      bit empty;
      had_last = 0; first_pending = 1; busy_cnt = 0;
      glog.delete();
      for (int c = 0; c < budget; c++) begin
         step();
         empty = 1;
         for (int i = 0; i < N; i++) if (src[i].size() > 0) empty = 0;
         if (empty && !bus.busy && exp_q.size() == 0) break;
      end
      chk("drain_in_budget", {bus.busy, 32'(exp_q.size())}, 0);
   endtask

`ifdef TX_ARB_WDOG_EN
   task automatic wdog_test();
      logic [7:0] d[6] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
      int aborts = 0;
      wb.req_valid = '0; wb.req_last = '0; wb.req_data = '0; wb.tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      wrst_n = 1'b1;
      @(negedge clk);
      wb.req_valid = 4'b0110; wb.req_last = 4'b0100; wb.req_data = {8'h00, 8'h20, d[0], 8'h00};
      #1 chk("wd_arb_idle", wb.tx_valid, 0);
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         wb.req_data[15:8] = d[b];
         #1 chk("wd_beat", {wb.tx_valid, wb.tx_data, wb.grant_id}, {1'b1, d[b], 2'd1});
      end
      repeat (8) begin
         @(negedge clk);
         wb.req_valid[1] = 1'b0;
         #1 chk("wd_stall", {wb.tx_valid, wb.tx_abort}, 0);
      end
      for (int b = 2; b < 6; b++) begin
         @(negedge clk);
         wb.req_valid[1] = 1'b1; wb.req_data[15:8] = d[b]; wb.req_last[1] = b == 5;
         #1 chk("wd_flush", {wb.tx_valid, wb.req_ready}, {1'b0, 4'b0010});
         aborts += int'(wb.tx_abort);
         if (b == 2) chk("wd_abort_pulse", wb.tx_abort, 1);
      end
      @(negedge clk);
      wb.req_valid[1] = 1'b0;
      #1 chk("wd_rearb", {wb.busy, wb.tx_valid}, 0);
      @(negedge clk);
      #1 chk("wd_next_grant", {wb.grant_id, wb.tx_valid, wb.tx_data, wb.tx_last}, {2'd2, 1'b1, 8'h20, 1'b1});
      chk("wd_abort_once", aborts, 1);
   endtask
`endif

   initial begin
      #900000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      vec_t vt[8];
      int fo[5] = '{0, 1, 2, 3, 0};
      int nf;
      vt = '{'{4'b0110, 1}, '{4'b0011, 0}, '{4'b1111, 1}, '{4'b1000, 3},
             '{4'b1010, 1}, '{4'b0010, 1}, '{4'b1101, 2}, '{4'b0101, 0}};
      clear_src();
      do_reset();
      #1 chk("reset_state", {bus.busy, bus.grant_id, bus.tx_valid, bus.tx_last, bus.tx_data, bus.req_ready}, 0);

      // arbitration table: single-beat frames, queue i carries byte A0+i
      foreach (vt[v]) begin
         @(negedge clk);
         bus.req_valid = vt[v].mask; bus.req_last = '1; bus.tx_ready = 1'b1;
         bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
         #1 chk("arb_idle", {bus.tx_valid, bus.busy}, 0);
         @(negedge clk);
         #1 chk("arb_grant", bus.grant_id, vt[v].exp_g);
         chk("arb_beat", {bus.tx_valid, bus.tx_last, bus.tx_data}, {2'b11, 8'(8'hA0 + vt[v].exp_g)});
         @(negedge clk);
         bus.req_valid = '0;
         repeat (IFG) @(negedge clk);
         #1 chk("grant_hold_idle", {bus.busy, bus.grant_id}, {1'b0, 2'(vt[v].exp_g)});
      end

      do_reset();
      load(2, 5, 8'h10); plan(); run_all(200);
      chk("single_busy_cycles", busy_cnt, 5 + IFG);

      do_reset();
      load(0, 3, 8'h00); load(0, 3, 8'h40); load(1, 3, 8'h10); load(2, 3, 8'h20); load(3, 3, 8'h30);
      plan(); run_all(400);
      chk("fair_frames", glog.size(), 5);
      nf = glog.size() < 5 ? glog.size() : 5;
      for (int i = 0; i < nf; i++) chk("fair_order", glog[i], fo[i]);

      do_reset();
      ready_mode = 1;
      load(1, 4, 8'h60); plan(); run_all(200);
      ready_mode = 0;

      do_reset();
      load(0, 6, 8'h70); load(3, 3, 8'h80);
      stall_after[0] = 2; stall_len[0] = 5;
      plan(); run_all(300);
      chk("underrun_busy_cycles", busy_cnt, 11 + IFG + 3 + IFG);

      do_reset();
      load(1, 1, 8'h90); plan(); run_all(100);
      load(3, 6, 8'hB0); plan();
      had_last = 0; first_pending = 1;
      repeat (4) step();
      @(negedge clk);
      rst_n_in = 1'b0;
      #1 chk("reset_mid_outputs", {bus.tx_valid, bus.tx_last, bus.tx_data, bus.req_ready, bus.busy, bus.grant_id}, 0);
      clear_src();
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n_in = 1'b1;
      m_ptr = 0;
      #1 chk("reset_release", {bus.busy, bus.grant_id}, 0);
      load(1, 2, 8'hC0); load(2, 2, 8'hD0); plan(); run_all(200);
      chk("reset_rr_winner", glog.size() > 0 ? glog[0] : -1, 1);

      for (int r = 0; r < 6; r++) begin
         ready_mode = r % 3 == 0 ? 0 : 2;
         underrun_pct = 25;
         for (int i = 0; i < N; i++)
            for (int f = $urandom_range(0, 2); f > 0; f--) load(i, $urandom_range(1, 5), $urandom_range(0, 255));
         load($urandom_range(0, N - 1), $urandom_range(1, 5), $urandom_range(0, 255));
         plan(); run_all(3000);
      end
      underrun_pct = 0; ready_mode = 0;

`ifdef TX_ARB_WDOG_EN
      wdog_test();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
